// File: rtl/message_stitcher_if.sv
// Slice-in / word-out bundle for the message stitcher.
// The master drives slices and the slave (the stitcher) drives the paced wide words.
interface message_stitcher_if #(
   parameter int WIDTH    = 32,
   parameter int N_SLICES = 2
);
   logic [WIDTH-1:0]          in_data;
   logic                      in_nd;
   logic                      in_first;
   logic [WIDTH*N_SLICES-1:0] out_data;
   logic                      out_nd;
   logic                      error;

   modport master (
      output in_data, in_nd, in_first,
      input  out_data, out_nd, error
   );

   modport slave (
      input  in_data, in_nd, in_first,
      output out_data, out_nd, error
   );
endinterface

// File: rtl/message_stitcher.sv
// Packs N_SLICES narrow slices into one wide word (first slice most significant),
// buffers words in a small FIFO and releases them as paced toggles on out_nd.
module message_stitcher #(
   parameter int N_SLICES          = 2,
   parameter int LOG_N_SLICES      = 1,
   parameter int WIDTH             = 32,
   parameter int BUFFER_LENGTH     = 8,
   parameter int LOG_BUFFER_LENGTH = 3,
   parameter int OUT_GAP           = 2
) (
   input logic               clk,
   input logic               rst_n,
   message_stitcher_if.slave bus
);

   localparam int WORD_W = WIDTH * N_SLICES;
   localparam int CNT_W  = (LOG_N_SLICES > 0) ? LOG_N_SLICES : 1;
   localparam int GAP_W  = (OUT_GAP > 1) ? $clog2(OUT_GAP) : 1;

   localparam logic [CNT_W-1:0]           LAST_SLOT  = CNT_W'(N_SLICES - 1);
   localparam logic [LOG_BUFFER_LENGTH:0] FULL       = (LOG_BUFFER_LENGTH + 1)'(BUFFER_LENGTH);
   localparam logic [GAP_W-1:0]           GAP_RELOAD = GAP_W'(OUT_GAP - 1);

   logic [CNT_W-1:0]             cnt;
   logic [CNT_W-1:0]             slot;
   logic [WORD_W-1:0]            asm_word;
   logic [WORD_W-1:0]            word_next;
   logic [WORD_W-1:0]            mem [BUFFER_LENGTH];
   logic [LOG_BUFFER_LENGTH-1:0] wr_ptr;
   logic [LOG_BUFFER_LENGTH-1:0] rd_ptr;
   logic [LOG_BUFFER_LENGTH:0]   occ;
   logic [GAP_W-1:0]             gap_cnt;
   logic                         push_req;
   logic                         push_ok;
   logic                         pop;
   logic                         misalign;

   // A flagged first slice always lands in slot 0, abandoning whatever partial word was in progress.
   always_comb begin
      slot      = bus.in_first ? '0 : cnt;
      word_next = asm_word;
      for (int i = 0; i < N_SLICES; i++) begin
         if (slot == CNT_W'(i)) begin
            word_next[(N_SLICES-1-i)*WIDTH +: WIDTH] = bus.in_data;
         end
      end
      push_req = bus.in_nd && (slot == LAST_SLOT);
      pop      = (occ != '0) && (gap_cnt == '0);
      push_ok  = push_req && ((occ != FULL) || pop);
      misalign = bus.in_nd && bus.in_first && (cnt != '0);
   end

   // Word storage carries no reset: its contents only matter once occupancy says so.
   always_ff @(posedge clk) begin
      if (bus.in_nd) begin
         asm_word <= word_next;
      end
      if (push_ok) begin
         mem[wr_ptr] <= word_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt          <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         occ          <= '0;
         gap_cnt      <= '0;
         bus.out_data <= '0;
         bus.out_nd   <= 1'b0;
         bus.error    <= 1'b0;
      end else begin
         if (bus.in_nd) begin
            cnt <= push_req ? '0 : slot + 1'b1;
         end

         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end

         case ({push_ok, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase

         // The gap counter restarts on every release, so toggles are never closer than OUT_GAP cycles.
         if (pop) begin
            gap_cnt      <= GAP_RELOAD;
            bus.out_data <= mem[rd_ptr];
            bus.out_nd   <= ~bus.out_nd;
            rd_ptr       <= rd_ptr + 1'b1;
         end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
         end

         if (misalign || (push_req && !push_ok)) begin
            bus.error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_message_stitcher.sv
// Scoreboard bench for message_stitcher: one instance paced at OUT_GAP=2, one at OUT_GAP=16.
module tb_message_stitcher;

   logic clk;
   logic rstA_n;
   logic rstB_n;

   int checks   = 0;
   int failures = 0;
   int cycle    = 0;

   logic [63:0] expA [$];
   logic [63:0] expB [$];
   int          toggleA [$];
   int          toggleB [$];

   logic prevA;
   logic prevB;
   int   lastA = -1000;
   int   lastB = -1000;

   message_stitcher_if #(.WIDTH(32), .N_SLICES(2)) ifA ();
   message_stitcher_if #(.WIDTH(32), .N_SLICES(2)) ifB ();

   message_stitcher #(.OUT_GAP(2)) dutA (
      .clk   (clk),
      .rst_n (rstA_n),
      .bus   (ifA.slave)
   );

   message_stitcher #(.OUT_GAP(16)) dutB (
      .clk   (clk),
      .rst_n (rstB_n),
      .bus   (ifB.slave)
   );

   // Free-running clock and a cycle count used to measure toggle spacing.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cycle++;

   // Hard time limit so a stuck run still ends with a report.
   initial begin
      #2000000;
      $display("[TB] FAIL timeout: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor for instance A: every out_nd edge must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rstA_n) begin
         prevA = 1'b0;
      end else if (ifA.out_nd !== prevA) begin
         prevA = ifA.out_nd;
         toggleA.push_back(cycle);
         checkOutput("gapA", 64'(cycle - lastA >= 2), 64'd1);
         lastA = cycle;
         if (expA.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpectedA: got word 0x%0h, expected none", ifA.out_data);
         end else begin
            checkOutput("wordA", ifA.out_data, expA.pop_front());
         end
      end
   end

   // Monitor for instance B, same rules with its wider output gap.
   always @(negedge clk) begin
      if (!rstB_n) begin
         prevB = 1'b0;
      end else if (ifB.out_nd !== prevB) begin
         prevB = ifB.out_nd;
         toggleB.push_back(cycle);
         checkOutput("gapB", 64'(cycle - lastB >= 16), 64'd1);
         lastB = cycle;
         if (expB.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpectedB: got word 0x%0h, expected none", ifB.out_data);
         end else begin
            checkOutput("wordB", ifB.out_data, expB.pop_front());
         end
      end
   end

   task automatic applyStimulus(input bit sel, input logic [31:0] data, input logic first);
      @(negedge clk);
      if (!sel) begin
         ifA.in_data  = data;
         ifA.in_nd    = 1'b1;
         ifA.in_first = first;
      end else begin
         ifB.in_data  = data;
         ifB.in_nd    = 1'b1;
         ifB.in_first = first;
      end
   endtask

   task automatic idle(input bit sel);
      @(negedge clk);
      if (!sel) begin
         ifA.in_nd    = 1'b0;
         ifA.in_first = 1'b0;
      end else begin
         ifB.in_nd    = 1'b0;
         ifB.in_first = 1'b0;
      end
   endtask

   task automatic waitDrain(input bit sel, input int budget);
      int n = 0;
      while (((!sel) ? expA.size() : expB.size()) != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (((!sel) ? expA.size() : expB.size()) != 0) begin
         failures++;
         $display("[TB] FAIL drain%s: %0d words still pending, expected 0",
                  sel ? "B" : "A", (!sel) ? expA.size() : expB.size());
         if (!sel) expA.delete(); else expB.delete();
      end
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      int          n0;

      rstA_n = 1'b0;
      rstB_n = 1'b0;
      ifA.in_data = '0; ifA.in_nd = 1'b0; ifA.in_first = 1'b0;
      ifB.in_data = '0; ifB.in_nd = 1'b0; ifB.in_first = 1'b0;
      repeat (3) @(negedge clk);
      rstA_n = 1'b1;
      rstB_n = 1'b1;
      @(negedge clk);

      $display("[TB] reset state");
      checkOutput("rstA_nd",   64'(ifA.out_nd), 64'd0);
      checkOutput("rstA_data", ifA.out_data,    64'd0);
      checkOutput("rstA_err",  64'(ifA.error),  64'd0);
      checkOutput("rstB_nd",   64'(ifB.out_nd), 64'd0);
      checkOutput("rstB_data", ifB.out_data,    64'd0);
      checkOutput("rstB_err",  64'(ifB.error),  64'd0);

      $display("[TB] single word latency");
      expA.push_back(64'h0000000A_0000000B);
      applyStimulus(0, 32'hA, 1'b1);
      applyStimulus(0, 32'hB, 1'b0);
      idle(0);
      checkOutput("lat_early", 64'(ifA.out_nd), 64'd0);
      @(negedge clk);
      checkOutput("lat_nd",   64'(ifA.out_nd), 64'd1);
      checkOutput("lat_data", ifA.out_data,    64'h0000000A_0000000B);
      checkOutput("lat_err",  64'(ifA.error),  64'd0);
      waitDrain(0, 20);

      $display("[TB] back-to-back burst of 8 slices");
      repeat (5) @(negedge clk);
      n0 = toggleA.size();
      for (int i = 1; i <= 8; i++) begin
         if (i % 2 == 0) expA.push_back({32'(i - 1), 32'(i)});
         applyStimulus(0, 32'(i), 1'(i % 2));
      end
      idle(0);
      waitDrain(0, 40);
      checkOutput("burst_count", 64'(toggleA.size() - n0), 64'd4);
      if (toggleA.size() == n0 + 4) begin
         for (int k = 1; k < 4; k++) begin
            checkOutput("burst_spacing", 64'(toggleA[n0+k] - toggleA[n0+k-1]), 64'd2);
         end
      end

      $display("[TB] random slice stream");
      for (int k = 0; k < 20; k++) begin
         a = $urandom;
         b = $urandom;
         expA.push_back({a, b});
         applyStimulus(0, a, 1'b1);
         applyStimulus(0, b, 1'b0);
         repeat ($urandom_range(0, 2)) idle(0);
      end
      idle(0);
      waitDrain(0, 200);
      checkOutput("rand_err", 64'(ifA.error), 64'd0);

      $display("[TB] misaligned first slice");
      expA.push_back(64'h00000009_00000006);
      applyStimulus(0, 32'h5, 1'b1);
      applyStimulus(0, 32'h9, 1'b1);
      applyStimulus(0, 32'h6, 1'b0);
      idle(0);
      waitDrain(0, 20);
      repeat (10) @(negedge clk);
      checkOutput("misalign_err", 64'(ifA.error), 64'd1);

      $display("[TB] overflow with slow output");
      for (int i = 1; i <= 24; i++) begin
         if (i % 2 == 0 && i <= 20) expB.push_back({32'(i - 1), 32'(i)});
         applyStimulus(1, 32'(i), 1'(i % 2));
         if (i == 21) checkOutput("ovf_err_before", 64'(ifB.error), 64'd0);
         if (i == 23) checkOutput("ovf_err_after",  64'(ifB.error), 64'd1);
      end
      idle(1);
      waitDrain(1, 400);
      repeat (40) @(negedge clk);
      checkOutput("ovf_no_extra", 64'(expB.size()), 64'd0);

      $display("[TB] reset with queued words");
      for (int i = 0; i < 8; i++) begin
         if (i == 1) expB.push_back(64'h00000011_00000012);
         applyStimulus(1, 32'h11 + 32'(i), 1'(i % 2 == 0));
      end
      idle(1);
      waitDrain(1, 20);
      checkOutput("pre_rst_nd", 64'(ifB.out_nd), 64'd1);
      rstB_n = 1'b0;
      #1;
      checkOutput("mid_rst_nd",   64'(ifB.out_nd), 64'd0);
      checkOutput("mid_rst_data", ifB.out_data,    64'd0);
      checkOutput("mid_rst_err",  64'(ifB.error),  64'd0);
      @(negedge clk);
      rstB_n = 1'b1;
      n0 = toggleB.size();
      repeat (40) @(negedge clk);
      checkOutput("post_rst_quiet", 64'(toggleB.size() - n0), 64'd0);
      expB.push_back(64'h00000021_00000022);
      applyStimulus(1, 32'h21, 1'b1);
      applyStimulus(1, 32'h22, 1'b0);
      idle(1);
      waitDrain(1, 20);
      checkOutput("post_rst_nd", 64'(ifB.out_nd), 64'd1);

      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
